// File: rtl/display_page_arbiter_if.sv
// Request/segment bundle between the two page sources (master side) and the
// display page arbiter (slave side); the arbiter outputs feed the digit-scan controller.
interface display_page_arbiter_if;
  logic        a_req;
  logic [41:0] a_seg;
  logic        b_req;
  logic [41:0] b_seg;
  logic        grant_a;
  logic        grant_b;
  logic [6:0]  out0;
  logic [6:0]  out1;
  logic [6:0]  out2;
  logic [6:0]  out3;
  logic [6:0]  out4;
  logic [6:0]  out5;

  modport master (
    output a_req, a_seg, b_req, b_seg,
    input  grant_a, grant_b, out0, out1, out2, out3, out4, out5
  );

  modport slave (
    input  a_req, a_seg, b_req, b_seg,
    output grant_a, grant_b, out0, out1, out2, out3, out4, out5
  );
endinterface

// File: rtl/display_page_arbiter.sv
// Grants the 6-digit display to page A (PWM status) or page B (alerts) with a minimum hold
// and a blank gap between pages. Optional macro DISPLAY_ARB_ROUND_ROBIN_EN enables round-robin.
module display_page_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  display_page_arbiter_if.slave  bus
);

  localparam logic [41:0]      SEG_OFF    = {6{7'h7F}};
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2,
    BLANK  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             grant_a_q;
  logic             grant_a_d;
  logic             grant_b_q;
  logic             grant_b_d;
  logic [41:0]      seg_q;
  logic [41:0]      seg_d;
  logic             hold_done;
  logic             blank_done;
  logic             pick_a;
  logic             pick_b;
  logic             leave_a;
  logic             leave_b;

`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
  // last_b_q = 1 when page B was the most recently shown page
  logic             last_b_q;
  logic             last_b_d;
`endif

  assign hold_done  = (cnt_q == HOLD_LAST);
  assign blank_done = (cnt_q == BLANK_LAST);

  always_comb begin
    pick_b = bus.b_req;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
    if (bus.a_req && bus.b_req) begin
      pick_b = ~last_b_q;
    end
`endif
    pick_a = bus.a_req && !pick_b;
  end

  assign leave_a = hold_done && (!bus.a_req || bus.b_req);
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
  assign leave_b = hold_done && (!bus.b_req || bus.a_req);
`else
  assign leave_b = hold_done && !bus.b_req;
`endif

  // IDLE and the last BLANK cycle share one arbitration path so the winner is
  // entered with its page loaded on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    seg_d     = SEG_OFF;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      IDLE, BLANK: begin
        if ((state_q == BLANK) && !blank_done) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
          if (pick_b) begin
            state_d   = SHOW_B;
            grant_b_d = 1'b1;
            seg_d     = bus.b_seg;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
            last_b_d  = 1'b1;
`endif
          end else if (pick_a) begin
            state_d   = SHOW_A;
            grant_a_d = 1'b1;
            seg_d     = bus.a_seg;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
            last_b_d  = 1'b0;
`endif
          end
        end
      end
      SHOW_A: begin
        if (leave_a) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          grant_a_d = 1'b1;
          seg_d     = bus.a_req ? bus.a_seg : seg_q;
          if (!hold_done) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      SHOW_B: begin
        if (leave_b) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          grant_b_d = 1'b1;
          seg_d     = bus.b_req ? bus.b_seg : seg_q;
          if (!hold_done) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      seg_q     <= SEG_OFF;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
      last_b_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      seg_q     <= seg_d;
`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  assign bus.grant_a = grant_a_q;
  assign bus.grant_b = grant_b_q;
  assign bus.out0    = seg_q[6:0];
  assign bus.out1    = seg_q[13:7];
  assign bus.out2    = seg_q[20:14];
  assign bus.out3    = seg_q[27:21];
  assign bus.out4    = seg_q[34:28];
  assign bus.out5    = seg_q[41:35];

endmodule

// File: tb/tb_display_page_arbiter.sv
// Directed-vector bench for display_page_arbiter with HOLD_CYCLES=8, BLANK_CYCLES=2;
// expectations adapt when DISPLAY_ARB_ROUND_ROBIN_EN is defined.
module tb_display_page_arbiter;

  localparam int unsigned HOLD  = 8;
  localparam int unsigned BLANK = 2;

`ifdef DISPLAY_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [41:0] OFF = {6{7'h7F}};
  localparam logic [41:0] PA1 = {{5{7'h40}}, 7'h79};
  localparam logic [41:0] PA2 = {{5{7'h40}}, 7'h24};
  localparam logic [41:0] PB  = {6{7'h12}};
  localparam logic [41:0] PB2 = {6{7'h30}};
  localparam logic [41:0] PR  = {6{7'h40}};

  typedef struct packed {
    logic        a_req;
    logic [41:0] a_seg;
    logic        b_req;
    logic [41:0] b_seg;
    logic        exp_ga;
    logic        exp_gb;
    logic [41:0] exp_seg;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [23];

  display_page_arbiter_if bus ();

  display_page_arbiter #(
    .HOLD_CYCLES  (HOLD),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] segs();
    return {bus.out5, bus.out4, bus.out3, bus.out2, bus.out1, bus.out0};
  endfunction

  function automatic vec_t mk(input logic ar, input logic [41:0] as, input logic br,
                              input logic [41:0] bs, input logic ga, input logic gb,
                              input logic [41:0] es);
    vec_t v;
    v.a_req   = ar;
    v.a_seg   = as;
    v.b_req   = br;
    v.b_seg   = bs;
    v.exp_ga  = ga;
    v.exp_gb  = gb;
    v.exp_seg = es;
    return v;
  endfunction

  task automatic compare(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic ga, input logic gb,
                             input logic [41:0] es);
    compare({name, ".grant_a"}, {41'd0, bus.grant_a}, {41'd0, ga});
    compare({name, ".grant_b"}, {41'd0, bus.grant_b}, {41'd0, gb});
    compare({name, ".seg"}, segs(), es);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ar, input logic [41:0] as, input logic br,
                               input logic [41:0] bs);
    bus.a_req = ar;
    bus.a_seg = as;
    bus.b_req = br;
    bus.b_seg = bs;
  endtask

  // Grants must be exclusive and a grant-free cycle must show an all-off display.
  always @(negedge clk) begin
    compare("exclusive", {41'd0, bus.grant_a & bus.grant_b}, 42'd0);
    compare("off_when_ungranted",
            (!bus.grant_a && !bus.grant_b) ? segs() : OFF, OFF);
  end

  initial begin
    logic        exp_ga;
    logic        exp_gb;
    logic [41:0] exp_seg;
    logic        a_turn;
    int          ph;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, OFF, 1'b0, OFF);

    vecs[0]  = mk(1'b0, OFF, 1'b0, OFF, 1'b0, 1'b0, OFF);
    vecs[1]  = mk(1'b1, PA1, 1'b0, PB,  1'b1, 1'b0, PA1);
    vecs[2]  = mk(1'b1, PA2, 1'b0, PB,  1'b1, 1'b0, PA2);
    for (int i = 3; i <= 8; i++) vecs[i] = mk(1'b1, PA2, 1'b1, PB, 1'b1, 1'b0, PA2);
    vecs[9]  = mk(1'b1, PA2, 1'b1, PB,  1'b0, 1'b0, OFF);
    vecs[10] = mk(1'b1, PA2, 1'b1, PB,  1'b0, 1'b0, OFF);
    vecs[11] = mk(1'b1, PA2, 1'b1, PB,  1'b0, 1'b1, PB);
    vecs[12] = mk(1'b0, PA2, 1'b1, PB2, 1'b0, 1'b1, PB2);
    for (int i = 13; i <= 18; i++) vecs[i] = mk(1'b0, PA2, 1'b0, PB, 1'b0, 1'b1, PB2);
    vecs[19] = mk(1'b1, PA2, 1'b0, PB,  1'b0, 1'b0, OFF);
    vecs[20] = mk(1'b1, PA2, 1'b0, PB,  1'b0, 1'b0, OFF);
    vecs[21] = mk(1'b0, PA2, 1'b0, PB,  1'b0, 1'b0, OFF);
    vecs[22] = mk(1'b0, PA2, 1'b0, PB,  1'b0, 1'b0, OFF);

    step();
    step();
    checkOutput("reset_state", 1'b0, 1'b0, OFF);
    rst = 1'b0;

    // Bring up page B, then hit reset between clock edges.
    applyStimulus(1'b0, OFF, 1'b1, PR);
    step();
    checkOutput("b_entry", 1'b0, 1'b1, PR);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, OFF);
    applyStimulus(1'b0, OFF, 1'b0, OFF);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("idle_after_reset", 1'b0, 1'b0, OFF);
    end

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].a_req, vecs[i].a_seg, vecs[i].b_req, vecs[i].b_seg);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ga, vecs[i].exp_gb, vecs[i].exp_seg);
    end

    // Both requests rise together and stay high; last page shown was B.
    applyStimulus(1'b1, PA1, 1'b1, PB);
    for (int i = 0; i < 30; i++) begin
      step();
      ph      = i % 10;
      a_turn  = RR && (((i / 10) % 2) == 0);
      exp_ga  = RR ? (ph < 8 && a_turn) : 1'b0;
      exp_gb  = RR ? (ph < 8 && !a_turn) : 1'b1;
      exp_seg = exp_ga ? PA1 : (exp_gb ? PB : OFF);
      checkOutput($sformatf("both_req_c%0d", i), exp_ga, exp_gb, exp_seg);
    end

    applyStimulus(1'b0, PA1, 1'b0, PB);
    for (int i = 0; i < 4; i++) step();
    checkOutput("drain_to_idle", 1'b0, 1'b0, OFF);

    // Last page shown was B in the fixed build and A in the round-robin build: B wins either way.
    applyStimulus(1'b1, PA1, 1'b1, PB);
    step();
    checkOutput("simultaneous_rise", 1'b0, 1'b1, PB);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
